mp_addsub_seq: RTL and testbench

- Multi-precision add/subtract sequencer built around the team's 32-bit carry-lookahead adder core (ports x, y, cIn, s, cOut).
- Processes WORDS 32-bit limbs serially, least-significant first, one limb per clock, with the carry chained through a register.
- Gives the ALU wide arithmetic (64/128/256-bit) without a wide combinational adder.
- Sits between a valid/ready operand source and a valid/ready result sink.

---
 rtl/mp_addsub_seq_pkg.sv | 30 +++
 rtl/mp_addsub_seq_if.sv | 31 +++
 rtl/mp_addsub_seq_cla.sv | 36 +++
 rtl/mp_addsub_seq.sv | 108 ++++++++++
 tb/tb_mp_addsub_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
// Holds the limb width, the FSM state encoding, the status flags and a lookahead group helper.
package mp_addsub_seq_pkg;

  localparam int LIMB_W = 32;
  localparam int GRP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic cOut;
    logic ovf;
    logic zero;
  } status_t;

  // Returns {groupGenerate, groupPropagate} for one 4-bit lookahead group.
  function automatic logic [1:0] groupGp(input logic [GRP_W-1:0] g, input logic [GRP_W-1:0] p);
    logic grpG;
    grpG = 1'b0;
    for (int i = 0; i < GRP_W; i++) begin
      grpG = g[i] | (p[i] & grpG);
    end
    return {grpG, &p};
  endfunction

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Operand/result bundle for mp_addsub_seq.
// Handshake: a transfer happens only on a rising edge where valid and ready are both high;
// a producer holds its payload stable while valid is high and ready is low.
interface mp_addsub_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 32 * WORDS;

  logic         inValid;
  logic         inReady;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] result;
  logic         cOut;
  logic         ovf;
  logic         zero;

  modport master (
    output inValid, a, b, sub, outReady,
    input  inReady, outValid, result, cOut, ovf, zero
  );

  modport slave (
    input  inValid, a, b, sub, outReady,
    output inReady, outValid, result, cOut, ovf, zero
  );

endinterface

// File: rtl/mp_addsub_seq_cla.sv
// 32-bit carry-lookahead adder core: 4-bit groups with group generate/propagate
// skipping the carry between groups. Purely combinational.
module mp_addsub_seq_cla
  import mp_addsub_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              cIn,
  output logic [LIMB_W-1:0] s,
  output logic              cOut
);

  logic [LIMB_W-1:0] gen;
  logic [LIMB_W-1:0] prop;

  assign gen  = x & y;
  assign prop = x ^ y;

  always_comb begin
    logic [LIMB_W:0] c;
    logic [1:0]      gp;
    c    = '0;
    gp   = '0;
    c[0] = cIn;
    for (int k = 0; k < LIMB_W / GRP_W; k++) begin
      for (int j = 1; j < GRP_W; j++) begin
        c[k*GRP_W+j] = gen[k*GRP_W+j-1] | (prop[k*GRP_W+j-1] & c[k*GRP_W+j-1]);
      end
      gp = groupGp(gen[k*GRP_W +: GRP_W], prop[k*GRP_W +: GRP_W]);
      c[(k+1)*GRP_W] = gp[1] | (gp[0] & c[k*GRP_W]);
    end
    s    = prop ^ c[LIMB_W-1:0];
    cOut = c[LIMB_W];
  end

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit limb per clock, LS limb first,
// carry chained through a register; subtraction is A + ~B + 1 with the +1 as initial carry.
module mp_addsub_seq
  import mp_addsub_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  mp_addsub_seq_if.slave bus,
  output state_t         dbgState
);

  localparam int W  = LIMB_W * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t            state;
  state_t            stateNext;
  logic [CW-1:0]     count;
  logic [W-1:0]      opA;
  logic [W-1:0]      opB;
  logic              opSub;
  logic              carry;
  logic              zeroAcc;
  logic [W-1:0]      resultReg;
  status_t           status;
  logic [LIMB_W-1:0] xLimb;
  logic [LIMB_W-1:0] yLimb;
  logic [LIMB_W-1:0] sLimb;
  logic              adderCOut;
  logic              lastLimb;

  assign lastLimb = (count == CW'(WORDS - 1));
  assign xLimb    = opA[count*LIMB_W +: LIMB_W];
  assign yLimb    = opB[count*LIMB_W +: LIMB_W] ^ {LIMB_W{opSub}};

  mp_addsub_seq_cla uCla (
    .x    (xLimb),
    .y    (yLimb),
    .cIn  (carry),
    .s    (sLimb),
    .cOut (adderCOut)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.inValid)  stateNext = RUN;
      RUN:     if (lastLimb)     stateNext = DONE;
      DONE:    if (bus.outReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      opA       <= '0;
      opB       <= '0;
      opSub     <= 1'b0;
      carry     <= 1'b0;
      zeroAcc   <= 1'b0;
      resultReg <= '0;
      status    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inValid) begin
            opA     <= bus.a;
            opB     <= bus.b;
            opSub   <= bus.sub;
            carry   <= bus.sub;
            count   <= '0;
            zeroAcc <= 1'b1;
          end
        end
        RUN: begin
          resultReg[count*LIMB_W +: LIMB_W] <= sLimb;
          carry   <= adderCOut;
          zeroAcc <= zeroAcc & (sLimb == '0);
          if (lastLimb) begin
            // Signed overflow = carry into the MSB XOR carry out of it.
            status.cOut <= adderCOut;
            status.ovf  <= sLimb[LIMB_W-1] ^ xLimb[LIMB_W-1] ^ yLimb[LIMB_W-1] ^ adderCOut;
            status.zero <= zeroAcc & (sLimb == '0);
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady  = (state == IDLE);
  assign bus.outValid = (state == DONE);
  assign bus.result   = resultReg;
  assign bus.cOut     = status.cOut;
  assign bus.ovf      = status.ovf;
  assign bus.zero     = status.zero;
  assign dbgState     = state;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: a WORDS=4 instance driven through a scoreboard
// and a WORDS=1 instance used after a mid-operation reset.
module tb_mp_addsub_seq;
  import mp_addsub_seq_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state4;
  state_t state1;

  always #5 clk = ~clk;

  mp_addsub_seq_if #(.WORDS(4)) bus4 ();
  mp_addsub_seq_if #(.WORDS(1)) bus1 ();

  mp_addsub_seq #(.WORDS(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus4.slave),
    .dbgState (state4)
  );

  mp_addsub_seq #(.WORDS(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus1.slave),
    .dbgState (state1)
  );

  // Scoreboard entries are {cOut, ovf, zero, result}.
  logic [130:0] exp_q[$];
  int           nChecks = 0;
  int           nErrors = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [130:0] model4(input logic [127:0] a, input logic [127:0] b,
                                          input logic s);
    logic [128:0] t;
    logic [127:0] r;
    logic         c;
    logic         v;
    if (s) begin
      r = a - b;
      c = (a >= b);
      v = (a[127] != b[127]) && (r[127] != a[127]);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      r = t[127:0];
      c = t[128];
      v = (a[127] == b[127]) && (r[127] != a[127]);
    end
    return {c, v, (r == 128'd0), r};
  endfunction

  function automatic logic [130:0] obs4();
    return {bus4.cOut, bus4.ovf, bus4.zero, bus4.result};
  endfunction

  task automatic drive4(input logic [127:0] a, input logic [127:0] b, input logic s);
    bus4.a       = a;
    bus4.b       = b;
    bus4.sub     = s;
    bus4.inValid = 1'b1;
    exp_q.push_back(model4(a, b, s));
  endtask

  // Latency is counted in cycles from the one where the handshake is presented
  // to the first cycle with outValid high.
  task automatic collect4();
    int n;
    int lat;
    n = 0;
    while (!bus4.inReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", (n < 40), 1'b1);
    @(negedge clk);
    bus4.inValid = 1'b0;
    lat = 1;
    while (!bus4.outValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 5);
    chk("queue_size", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("result4", obs4(), exp_q.pop_front());
  endtask

  task automatic release4();
    bus4.outReady = 1'b1;
    @(negedge clk);
    bus4.outReady = 1'b0;
    chk("released", bus4.outValid, 1'b0);
  endtask

  task automatic runOp(input logic [127:0] a, input logic [127:0] b, input logic s);
    drive4(a, b, s);
    collect4();
    release4();
  endtask

  initial begin
    logic [130:0] snap;
    logic [127:0] ra;
    int           lat1;

    bus4.inValid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.outReady = 1'b0;
    bus1.inValid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.outReady = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_inReady4", bus4.inReady, 1'b1);
    chk("rst_outValid4", bus4.outValid, 1'b0);
    chk("rst_outputs4", obs4(), '0);
    chk("rst_inReady1", bus1.inReady, 1'b1);
    chk("rst_outputs1", {bus1.outValid, bus1.cOut, bus1.ovf, bus1.zero, bus1.result}, '0);
    rst = 1'b0;
    @(negedge clk);

    runOp({128{1'b1}}, 128'd1, 1'b0);
    chk("max_plus_one", obs4(), {1'b1, 1'b0, 1'b1, 128'd0});
    runOp(128'd0, 128'd1, 1'b1);
    runOp({1'b0, {127{1'b1}}}, 128'd1, 1'b0);
    runOp({1'b1, 127'd0}, 128'd1, 1'b1);
    runOp(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0);
    chk("limb_chain", obs4(), {1'b0, 1'b0, 1'b0, 128'h00000001_00000000_00000000_00000000});

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i == 5) runOp(ra, ra, 1'b1);
      else        runOp(ra, {$urandom(), $urandom(), $urandom(), $urandom()},
                        1'($urandom_range(0, 1)));
    end

    // Backpressure with a new operation waiting on the input side.
    drive4(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'h0000_0000_ffff_ffff_0000_0001_ffff_ffff, 1'b0);
    collect4();
    drive4(128'h0000_0000_0000_0005_0000_0000_0000_0003, 128'h0000_0000_0000_0007_0000_0000_0000_0004, 1'b1);
    snap = obs4();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_inReady", bus4.inReady, 1'b0);
      chk("bp_outValid", bus4.outValid, 1'b1);
      chk("bp_stable", obs4(), snap);
    end
    release4();
    chk("bp_idle_ready", bus4.inReady, 1'b1);
    collect4();
    release4();

    // Reset while the WORDS=4 instance is on its third limb.
    drive4(128'hdead_beef_0000_0001_0000_0002_0000_0003, 128'h1, 1'b1);
    repeat (3) @(negedge clk);
    chk("mid_run_state", state4, RUN);
    rst = 1'b1;
    bus4.inValid = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_outValid", bus4.outValid, 1'b0);
    chk("abort_outputs", obs4(), '0);
    chk("abort_inReady", bus4.inReady, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", bus4.outValid, 1'b0);
    end

    bus1.a = 32'd5; bus1.b = 32'd7; bus1.sub = 1'b0; bus1.inValid = 1'b1;
    @(negedge clk);
    bus1.inValid = 1'b0;
    lat1 = 1;
    while (!bus1.outValid && lat1 < 40) begin
      @(negedge clk);
      lat1++;
    end
    chk("w1_latency", lat1, 2);
    chk("w1_result", {bus1.cOut, bus1.ovf, bus1.zero, bus1.result}, {3'b000, 32'd12});
    bus1.outReady = 1'b1;
    @(negedge clk);
    bus1.outReady = 1'b0;
    chk("w1_released", bus1.outValid, 1'b0);

    runOp(128'd5, 128'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", nErrors, nChecks);
    $fatal(1);
  end

endmodule
